// File: rtl/shiftreg_xfer_engine.sv
// Universal shift register with a built-in transfer sequencer.
// Loads a word on start, then shifts a programmed number of bits on bit ticks.
module shiftreg_xfer_engine #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         dir,
    input  logic [COUNT_W-1:0] nbits,
    input  logic [WIDTH-1:0]   load_data,
    input  logic               shift_en,
    input  logic               serial_in,
    output logic               serial_out,
    output logic [WIDTH-1:0]   parallel_out,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] bit_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] D_LEFT  = 2'b00;
    localparam logic [1:0] D_RIGHT = 2'b01;
    localparam logic [1:0] D_ROTL  = 2'b10;
    localparam logic [1:0] D_ROTR  = 2'b11;

    localparam logic [COUNT_W-1:0] FULL = COUNT_W'(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [1:0]         dir_q, dir_d;
    logic [COUNT_W-1:0] target_q, target_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [COUNT_W-1:0] cnt_inc;
    logic [COUNT_W-1:0] nbits_clamped;
    logic [WIDTH-1:0]   shifted;

    // 0 or anything beyond the register width means a full-word transfer
    always_comb begin
        nbits_clamped = nbits;
        if (nbits == '0 || nbits > FULL) begin
            nbits_clamped = FULL;
        end
    end

    // One-step shift of the register according to the latched direction
    always_comb begin
        shifted = sreg_q;
        unique case (dir_q)
            D_LEFT:  shifted = {sreg_q[WIDTH-2:0], serial_in};
            D_RIGHT: shifted = {serial_in, sreg_q[WIDTH-1:1]};
            D_ROTL:  shifted = {sreg_q[WIDTH-2:0], sreg_q[WIDTH-1]};
            D_ROTR:  shifted = {sreg_q[0], sreg_q[WIDTH-1:1]};
            default: shifted = sreg_q;
        endcase
    end

    assign cnt_inc = cnt_q + COUNT_W'(1);

    // Sequencer: next state and next datapath values, holding by default
    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        dir_d    = dir_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            S_SHIFT: begin
                if (shift_en) begin
                    sreg_d = shifted;
                    cnt_d  = cnt_inc;
                    if (cnt_inc == target_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_IDLE, S_DONE: begin
                // a start in DONE chains straight into the next transfer
                if (start) begin
                    sreg_d   = load_data;
                    dir_d    = dir;
                    target_d = nbits_clamped;
                    cnt_d    = '0;
                    state_d  = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            sreg_q   <= '0;
            dir_q    <= D_LEFT;
            target_q <= FULL;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            dir_q    <= dir_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
        end
    end

    // Outgoing bit is the end the register is moving towards
    assign serial_out   = dir_q[0] ? sreg_q[0] : sreg_q[WIDTH-1];
    assign parallel_out = sreg_q;
    assign busy         = (state_q == S_SHIFT);
    assign done         = (state_q == S_DONE);
    assign bit_count    = cnt_q;

endmodule

// File: tb/tb_shiftreg_xfer_engine.sv
// Bench for shiftreg_xfer_engine: directed transfers, with a done-pulse
// scoreboard fed by the stimulus and drained by an independent monitor.
module tb_shiftreg_xfer_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] dir;
    logic [3:0] nbits;
    logic [7:0] load_data;
    logic       shift_en;
    logic       serial_in;
    logic       serial_out;
    logic [7:0] parallel_out;
    logic       busy;
    logic       done;
    logic [3:0] bit_count;

    shiftreg_xfer_engine #(.WIDTH(8), .COUNT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .dir          (dir),
        .nbits        (nbits),
        .load_data    (load_data),
        .shift_en     (shift_en),
        .serial_in    (serial_in),
        .serial_out   (serial_out),
        .parallel_out (parallel_out),
        .busy         (busy),
        .done         (done),
        .bit_count    (bit_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         cnt;
        int         blen;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic chk_idle_zero(input string name);
        chk({name, ".data"}, int'(parallel_out), 0);
        chk({name, ".sout"}, int'(serial_out), 0);
        chk({name, ".busy"}, int'(busy), 0);
        chk({name, ".done"}, int'(done), 0);
        chk({name, ".cnt"}, int'(bit_count), 0);
    endtask

    // Monitor: on every done pulse pop and compare the expected result
    int   run_len = 0;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (prev_done) begin
                chk("mon.done_width", 2, 1);
            end
            if (exp_q.size() == 0) begin
                chk("mon.unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("mon.data", int'(parallel_out), int'(e.data));
                chk("mon.cnt", int'(bit_count), e.cnt);
                chk("mon.busy_len", run_len, e.blen);
            end
            run_len = 0;
        end else if (busy === 1'b1) begin
            run_len++;
        end else begin
            run_len = 0;
        end
        prev_done = (done === 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    logic [7:0] pat2;
    logic [7:0] exp3 [3];

    initial begin
        pat2 = 8'hA5;
        exp3 = '{8'hC0, 8'h60, 8'h30};
        reset = 1'b1;
        start = 1'b0;
        dir = 2'b00;
        nbits = 4'd0;
        load_data = 8'h00;
        shift_en = 1'b0;
        serial_in = 1'b0;

        // T1: reset for 2 clks with random inputs
        for (int i = 0; i < 2; i++) begin
            start     = 1'($urandom);
            shift_en  = 1'($urandom);
            dir       = 2'($urandom);
            nbits     = 4'($urandom);
            load_data = 8'($urandom);
            serial_in = 1'($urandom);
            @(negedge clk);
            chk_idle_zero("t1.reset");
        end
        reset = 1'b0;
        start = 1'b0;
        shift_en = 1'b0;
        @(negedge clk);
        chk_idle_zero("t1.idle");

        // T2: LEFT 0xA5, nbits=0 -> 8 shifts filling with ones
        dir = 2'b00; nbits = 4'd0; load_data = 8'hA5;
        serial_in = 1'b1; shift_en = 1'b1; start = 1'b1;
        exp_q.push_back('{8'hFF, 8, 8});
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t2.sout", int'(serial_out), int'(pat2[7-i]));
            chk("t2.busy", int'(busy), 1);
            @(negedge clk);
        end
        chk("t2.done", int'(done), 1);
        chk("t2.data", int'(parallel_out), 8'hFF);
        chk("t2.cnt", int'(bit_count), 8);
        @(negedge clk);
        chk("t2.done_off", int'(done), 0);
        chk("t2.hold", int'(parallel_out), 8'hFF);

        // T3: ROTR 0x81, nbits=3, serial_in toggling
        dir = 2'b11; nbits = 4'd3; load_data = 8'h81; start = 1'b1;
        exp_q.push_back('{8'h30, 3, 3});
        @(negedge clk);
        start = 1'b0;
        chk("t3.sout0", int'(serial_out), 1);
        for (int i = 0; i < 3; i++) begin
            serial_in = ~serial_in;
            @(negedge clk);
            chk("t3.data", int'(parallel_out), int'(exp3[i]));
        end
        chk("t3.done", int'(done), 1);
        @(negedge clk);

        // T4: RIGHT 0x0F, nbits=4, shift_en on alternate clks
        dir = 2'b01; nbits = 4'd4; load_data = 8'h0F;
        serial_in = 1'b0; shift_en = 1'b0; start = 1'b1;
        exp_q.push_back('{8'h00, 4, 8});
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t4.cnt", int'(bit_count), i / 2);
            shift_en = 1'(i % 2);
            @(negedge clk);
        end
        chk("t4.done", int'(done), 1);
        chk("t4.data", int'(parallel_out), 8'h00);
        shift_en = 1'b1;
        serial_in = 1'b1;
        @(negedge clk);
        chk("t4.hold_data", int'(parallel_out), 8'h00);
        chk("t4.hold_cnt", int'(bit_count), 4);
        shift_en = 1'b0;

        // T5: start ignored in SHIFT, then reset aborts without done
        dir = 2'b00; nbits = 4'd0; load_data = 8'h5A;
        serial_in = 1'b0; shift_en = 1'b1; start = 1'b1;
        @(negedge clk);
        load_data = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t5.data", int'(parallel_out), 8'hD0);
        chk("t5.cnt", int'(bit_count), 3);
        reset = 1'b1;
        @(negedge clk);
        chk_idle_zero("t5.reset");
        reset = 1'b0;
        shift_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5.no_done", int'(done), 0);
        end

        // T6: nbits=12 clamps to 8, then back-to-back ROTL 0x3C
        dir = 2'b00; nbits = 4'd12; load_data = 8'h12;
        serial_in = 1'b0; shift_en = 1'b1; start = 1'b1;
        exp_q.push_back('{8'h00, 8, 8});
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("t6.done", int'(done), 1);
        dir = 2'b10; nbits = 4'd2; load_data = 8'h3C; start = 1'b1;
        exp_q.push_back('{8'hF0, 2, 2});
        @(negedge clk);
        chk("t6.b2b_busy", int'(busy), 1);
        chk("t6.b2b_done", int'(done), 0);
        chk("t6.b2b_data", int'(parallel_out), 8'h3C);
        chk("t6.b2b_cnt", int'(bit_count), 0);
        start = 1'b0;
        @(negedge clk);
        chk("t6.rotl1", int'(parallel_out), 8'h78);
        @(negedge clk);
        chk("t6.done2", int'(done), 1);
        chk("t6.final", int'(parallel_out), 8'hF0);

        repeat (3) @(negedge clk);
        chk("sb.pending", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
